// File: rtl/ir_nec_decoder.sv
// NEC IR receive decoder: measures mark/space durations in prescaled ticks and assembles 32-bit frames.
// Optional build macro IR_INVERT_CHECK_EN gates commit on the command/inverted-command byte check.
module ir_nec_decoder #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_US     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_rx,
    output logic [31:0] ir_command,
    output logic        ir_data_ready,
    output logic        ir_repeat,
    output logic        ir_error,
    output logic        busy
);

    localparam int PRESC = CLK_FREQ_HZ / 1_000_000 * TICK_US;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_MARK
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    sync_q;
    logic [PW-1:0] presc_q;
    logic [10:0]   dur_q;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   shift_q, shift_d, shift_ins;
    logic [31:0]   cmd_q, cmd_d;
    logic          rdy_q, rdy_d, rpt_q, rpt_d, err_q, err_d;
    logic          tick, rise, fall, edge_s;
    logic [10:0]   phase_max;
    logic          bit_zero, bit_one;

    function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Synchroniser resets to the idle (high) level so release never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= 3'b111;
        else        sync_q <= {sync_q[1:0], ir_rx};
    end

    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];
    assign edge_s = rise | fall;
    assign tick   = (presc_q == PW'(PRESC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            dur_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (edge_s)
                dur_q <= '0;
            else if (tick && dur_q != 11'd2047)
                dur_q <= dur_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
            rpt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            rpt_q   <= rpt_d;
            err_q   <= err_d;
        end
    end

    assign bit_zero = in_win(dur_q, 11'd40, 11'd70);
    assign bit_one  = in_win(dur_q, 11'd140, 11'd200);

    always_comb begin
        shift_ins        = shift_q;
        shift_ins[idx_q] = bit_one;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        cmd_d     = cmd_q;
        rdy_d     = 1'b0;
        rpt_d     = 1'b0;
        err_d     = 1'b0;
        phase_max = 11'd2047;
        case (state_q)
            LEAD_MARK:  phase_max = 11'd1000;
            LEAD_SPACE: phase_max = 11'd500;
            BIT_SPACE:  phase_max = 11'd200;
            BIT_MARK, STOP_MARK, RPT_MARK: phase_max = 11'd70;
            default:    phase_max = 11'd2047;
        endcase

        if (edge_s) begin
            case (state_q)
                IDLE: if (fall) state_d = LEAD_MARK;
                LEAD_MARK: begin
                    if (in_win(dur_q, 11'd800, 11'd1000)) state_d = LEAD_SPACE;
                    else begin state_d = IDLE; err_d = 1'b1; end
                end
                LEAD_SPACE: begin
                    if (in_win(dur_q, 11'd400, 11'd500)) begin
                        state_d = BIT_MARK;
                        idx_d   = '0;
                        shift_d = '0;
                    end else if (in_win(dur_q, 11'd200, 11'd250)) begin
                        state_d = RPT_MARK;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                BIT_MARK: begin
                    if (in_win(dur_q, 11'd40, 11'd70)) state_d = BIT_SPACE;
                    else begin state_d = IDLE; err_d = 1'b1; end
                end
                BIT_SPACE: begin
                    if (bit_zero || bit_one) begin
                        shift_d = shift_ins;
                        if (idx_q == 5'd31) begin
                            state_d = STOP_MARK;
`ifdef IR_INVERT_CHECK_EN
                            if (shift_ins[31:24] == ~shift_ins[23:16]) begin
                                cmd_d = shift_ins;
                                rdy_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
`else
                            cmd_d = shift_ins;
                            rdy_d = 1'b1;
`endif
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = BIT_MARK;
                        end
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
                // A bad stop mark only flags; data committed one phase earlier stands.
                STOP_MARK: begin
                    state_d = IDLE;
                    err_d   = !in_win(dur_q, 11'd40, 11'd70);
                end
                RPT_MARK: begin
                    state_d = IDLE;
                    if (in_win(dur_q, 11'd40, 11'd70)) rpt_d = 1'b1;
                    else                               err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tick && dur_q >= phase_max) begin
            // Timeout on the tick that would carry the count past the phase maximum.
            state_d = IDLE;
            err_d   = 1'b1;
        end
    end

    assign ir_command    = cmd_q;
    assign ir_data_ready = rdy_q;
    assign ir_repeat     = rpt_q;
    assign ir_error      = err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed bench for ir_nec_decoder; one tick per clock so NEC timings are driven directly in ticks.
module tb_ir_nec_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_rx = 1'b1;
    logic [31:0] ir_command;
    logic        ir_data_ready, ir_repeat, ir_error, busy;

    int errs = 0, checks = 0;
    int n_rdy = 0, n_rpt = 0, n_err = 0, n_multi = 0;
    int rdy_lat;
    logic [31:0] pre_cmd, r_cmd;
    logic [3:0]  r_flags;

    ir_nec_decoder #(.CLK_FREQ_HZ(1_000_000), .TICK_US(1)) dut (
        .clk(clk), .rst_n(rst_n), .ir_rx(ir_rx), .ir_command(ir_command),
        .ir_data_ready(ir_data_ready), .ir_repeat(ir_repeat), .ir_error(ir_error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ir_data_ready) n_rdy++;
        if (ir_repeat)     n_rpt++;
        if (ir_error)      n_err++;
        if (int'(ir_data_ready) + int'(ir_repeat) + int'(ir_error) > 1) n_multi++;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic phase(input logic lvl, input int n);
        ir_rx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // rst_at >= 0 pulses reset during that bit's space and snapshots outputs.
    task automatic send_frame(input logic [31:0] c, input int rst_at);
        phase(1'b0, 900);
        phase(1'b1, 450);
        for (int i = 0; i < 32; i++) begin
            phase(1'b0, 56);
            if (i == rst_at) begin
                phase(1'b1, 20);
                rst_n = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                r_cmd   = ir_command;
                r_flags = {ir_data_ready, ir_repeat, ir_error, busy};
                rst_n   = 1'b1;
                phase(1'b1, c[i] ? 149 : 36);
            end else begin
                phase(1'b1, c[i] ? 169 : 56);
            end
        end
        pre_cmd = ir_command;
        ir_rx   = 1'b0;
        rdy_lat = -1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (ir_data_ready && rdy_lat < 0) rdy_lat = k;
        end
        phase(1'b0, 50);
        phase(1'b1, 300);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ir_rx = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++; if (ir_command !== 32'h0) begin errs++; $display("FAIL reset_cmd got=%h exp=0", ir_command); end
        checks++; if ({ir_data_ready, ir_repeat, ir_error} !== 3'b000) begin errs++; $display("FAIL reset_strobes got=%b exp=000", {ir_data_ready, ir_repeat, ir_error}); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        phase(1'b1, 10);
    endtask

    task automatic test_frame;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(32'hE9166B86, -1);
        checks++; if (ir_command !== 32'hE9166B86) begin errs++; $display("FAIL frame_cmd got=%h exp=e9166b86", ir_command); end
        checks++; if (n_rdy - r0 !== 1) begin errs++; $display("FAIL frame_rdy_count got=%0d exp=1", n_rdy - r0); end
        checks++; if (rdy_lat !== 3) begin errs++; $display("FAIL frame_rdy_latency got=%0d exp=3", rdy_lat); end
        checks++; if (n_err - e0 !== 0) begin errs++; $display("FAIL frame_err_count got=%0d exp=0", n_err - e0); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL frame_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_repeat;
        int r0, p0, e0;
        r0 = n_rdy; p0 = n_rpt; e0 = n_err;
        phase(1'b0, 900);
        phase(1'b1, 225);
        phase(1'b0, 56);
        phase(1'b1, 200);
        checks++; if (n_rpt - p0 !== 1) begin errs++; $display("FAIL repeat_count got=%0d exp=1", n_rpt - p0); end
        checks++; if (n_rdy - r0 !== 0 || n_err - e0 !== 0) begin errs++; $display("FAIL repeat_other_strobes got rdy=%0d err=%0d exp=0", n_rdy - r0, n_err - e0); end
        checks++; if (ir_command !== 32'hE9166B86) begin errs++; $display("FAIL repeat_cmd got=%h exp=e9166b86", ir_command); end
    endtask

    task automatic test_back_to_back;
        int r0;
        r0 = n_rdy;
        send_frame(32'hF30C6B86, -1);
        checks++; if (ir_command !== 32'hF30C6B86) begin errs++; $display("FAIL b2b_first got=%h exp=f30c6b86", ir_command); end
        send_frame(32'hED126B86, -1);
        checks++; if (pre_cmd !== 32'hF30C6B86) begin errs++; $display("FAIL b2b_hold got=%h exp=f30c6b86", pre_cmd); end
        checks++; if (ir_command !== 32'hED126B86) begin errs++; $display("FAIL b2b_second got=%h exp=ed126b86", ir_command); end
        checks++; if (n_rdy - r0 !== 2) begin errs++; $display("FAIL b2b_rdy_count got=%0d exp=2", n_rdy - r0); end
    endtask

    task automatic test_invert_check;
        int r0, e0;
        r0 = n_rdy; e0 = n_err;
        send_frame(32'hE8166B86, -1);
`ifdef IR_INVERT_CHECK_EN
        checks++; if (ir_command !== 32'hED126B86) begin errs++; $display("FAIL inv_cmd got=%h exp=ed126b86", ir_command); end
        checks++; if (n_rdy - r0 !== 0) begin errs++; $display("FAIL inv_rdy got=%0d exp=0", n_rdy - r0); end
        checks++; if (n_err - e0 !== 1) begin errs++; $display("FAIL inv_err got=%0d exp=1", n_err - e0); end
`else
        checks++; if (ir_command !== 32'hE8166B86) begin errs++; $display("FAIL inv_cmd got=%h exp=e8166b86", ir_command); end
        checks++; if (n_rdy - r0 !== 1) begin errs++; $display("FAIL inv_rdy got=%0d exp=1", n_rdy - r0); end
        checks++; if (n_err - e0 !== 0) begin errs++; $display("FAIL inv_err got=%0d exp=0", n_err - e0); end
`endif
    endtask

    task automatic test_errors;
        int lat;
        logic [31:0] c0;
        c0 = ir_command;
        phase(1'b0, 500);
        ir_rx = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ir_error && lat < 0) lat = k;
        end
        checks++; if (lat !== 3) begin errs++; $display("FAIL short_leader_err_latency got=%0d exp=3", lat); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL short_leader_busy got=%b exp=0", busy); end
        phase(1'b1, 100);
        phase(1'b0, 900);
        phase(1'b1, 450);
        phase(1'b0, 56);
        ir_rx = 1'b1;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (ir_error && lat < 0) lat = k;
        end
        checks++; if (lat !== 204) begin errs++; $display("FAIL space_timeout_latency got=%0d exp=204", lat); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL space_timeout_busy got=%b exp=0", busy); end
        checks++; if (ir_command !== c0) begin errs++; $display("FAIL abort_cmd_held got=%h exp=%h", ir_command, c0); end
    endtask

    task automatic test_reset_midframe;
        send_frame(32'hE9166B86, 15);
        checks++; if (r_cmd !== 32'h0) begin errs++; $display("FAIL midrst_cmd got=%h exp=0", r_cmd); end
        checks++; if (r_flags !== 4'b0000) begin errs++; $display("FAIL midrst_flags got=%b exp=0000", r_flags); end
        checks++; if (ir_command !== 32'h0) begin errs++; $display("FAIL midrst_partial_ignored got=%h exp=0", ir_command); end
        send_frame(32'hF30C6B86, -1);
        checks++; if (ir_command !== 32'hF30C6B86) begin errs++; $display("FAIL midrst_next_frame got=%h exp=f30c6b86", ir_command); end
        checks++; if (rdy_lat !== 3) begin errs++; $display("FAIL midrst_rdy_latency got=%0d exp=3", rdy_lat); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_repeat();
        test_back_to_back();
        test_invert_check();
        test_errors();
        test_reset_midframe();
        checks++; if (n_multi !== 0) begin errs++; $display("FAIL one_strobe_per_cycle got=%0d exp=0", n_multi); end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Receive-side NEC infrared decoder for the robot's remote-control path. It samples the demodulated, active-low IR receiver output, measures mark and space durations against NEC windows, and assembles the 32-bit frame. It then presents the frame as `ir_command` / `ir_data_ready`, the exact pair the drive logic consumes. Both 32-bit and repeat frames are recognised; malformed frames are flagged and dropped.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `TICK_US`, 10, measurement tick period in µs; prescaler terminal count = CLK_FREQ_HZ/1_000_000*TICK_US (500 at default).
- `clk`  input  1  system clock, all logic on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `ir_rx`  input  1  demodulated IR receiver output, asynchronous, active-low (low = carrier burst = mark).
- `ir_command`  output  32  last valid frame, first-received bit in bit 0: {~cmd, cmd, addr_hi, addr_lo}.
- `ir_data_ready`  output  1  one-cycle strobe, new `ir_command` valid.
- `ir_repeat`  output  1  one-cycle strobe, NEC repeat frame received.
- `ir_error`  output  1  one-cycle strobe, frame aborted.
- `busy`  output  1  high while decoder is outside IDLE.

## Operation
- `ir_rx` passes a 2-FF synchroniser; edges are detected on the synchronised value.
- Prescaler produces a 1-cycle tick every TICK_US. An 11-bit duration counter counts ticks, saturates at 2047, and clears on every edge of the synchronised `ir_rx`.
- On each edge the duration of the phase just ended is classified (ticks, inclusive):
  - leader mark 800–1000
  - leader space 400–500 (data) / 200–250 (repeat)
  - bit mark 40–70
  - bit space 40–70 → 0, 140–200 → 1
  - stop mark 40–70
- States:
  - IDLE → LEAD_MARK on falling edge.
  - LEAD_MARK → LEAD_SPACE on rising edge, if in window.
  - LEAD_SPACE → BIT_MARK on falling edge with data window (bit index := 0), or → RPT_MARK with repeat window.
  - BIT_MARK → BIT_SPACE on rising edge, if in window.
  - BIT_SPACE → on falling edge, shift classified bit into shift[index]. Go to BIT_MARK if index < 31, else STOP_MARK and commit.
  - STOP_MARK / RPT_MARK → IDLE on rising edge. RPT_MARK pulses `ir_repeat` if in window.
- Abort: in any non-IDLE state, go to IDLE with an `ir_error` strobe when:
  - an edge ends a phase outside its window, or
  - the counter exceeds the current phase maximum with no edge (timeout; fires on the tick that passes the max).
- Abort leaves `ir_command` unchanged.
- Commit: shift register value → `ir_command`, `ir_data_ready` strobe. With the check enabled, the check below gates the commit.
- Stop-mark window failure after commit raises `ir_error` only; the committed data stands.
- Reset values:
  - `ir_command` = 0
  - all strobes 0
  - `busy` = 0
  - state IDLE, counters 0
- Reset mid-frame discards the partial frame. A frame already in progress when reset releases is not decoded; decoding resumes from the next falling edge.

## Timing
- Edge-to-action latency: 3 clk cycles (2 synchroniser, 1 registered decision).
- `ir_data_ready` rises 3 cycles after the `ir_rx` falling edge that ends bit 31's space, and lasts exactly 1 cycle.
- `ir_command` updates in the same cycle as `ir_data_ready` rises and is held until the next commit.
- Duration measurement resolution: ±1 tick.
- At most one strobe (`ir_data_ready`, `ir_repeat`, `ir_error`) is asserted per cycle. If commit and abort coincide, commit wins.
- `busy` rises 3 cycles after the leader falling edge. It falls the cycle the state returns to IDLE.

## Configuration
- `IR_INVERT_CHECK_EN` defined: commit requires shift[31:24] == ~shift[23:16]. On mismatch: no commit, `ir_error` strobe instead of `ir_data_ready`.
- `IR_INVERT_CHECK_EN` undefined: any well-timed 32-bit frame commits.

## Test plan
- Full NEC frame 0xE9166B86 (leader 9 ms/4.5 ms, 562.5 µs marks) → one `ir_data_ready` pulse 3 cycles after bit-31 space end; `ir_command` = 0xE9166B86; `ir_error` never asserted.
- Two back-to-back frames, 0xF30C6B86 then 0xED126B86 → two strobes; `ir_command` holds 0xF30C6B86 until the second commit.
- Repeat frame (9 ms, 2.25 ms, 562.5 µs) after a 0xE9166B86 frame → one `ir_repeat` pulse; `ir_command` stays 0xE9166B86.
- Frame 0xE8166B86 → with `IR_INVERT_CHECK_EN`: `ir_error` pulse, no `ir_data_ready`, `ir_command` unchanged. Without it: `ir_command` = 0xE8166B86.
- Leader mark 5 ms → `ir_error` at the rising edge. Bit space held 3 ms → `ir_error` on the tick where the count reaches 201. Both cases return to IDLE with `busy` = 0.
- `rst_n` low for 2 cycles during bit 15 → all outputs 0 next cycle. The rest of that frame is ignored; the following frame 0xF30C6B86 decodes correctly.
